id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection and hazard control for the 5-stage RV32I pipeline.
- Captures decoded fields from Decode on each clock edge.
- Forwards results from Memory/Writeback, drives SrcA/SrcB/ALUControl into the ALU, and consumes ALU Zero to resolve branches.
- Generates stall/flush controls for Fetch/Decode.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RA_W, 5, register address width.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- RD1D, RD2D  in  XLEN  register-file read data from Decode
- ImmExtD, PCD, PCPlus4D  in  XLEN  immediate, PC and PC+4 from Decode
- Rs1D, Rs2D, RdD  in  RA_W  register addresses from Decode
- ALUControlD  in  3  ALU op (`ALU_CTRL_*`)
- ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD  in  1  decoded controls
- ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
- Funct3D  in  3  branch condition
- ALUResultM  in  XLEN  Memory-stage result, for forwarding
- RdM, RdW  in  RA_W; RegWriteM, RegWriteW  in  1  forwarding sources
- ResultW  in  XLEN  Writeback result
- ZeroE  in  1  ALU Zero flag
- SrcAE, SrcBE  out  XLEN  ALU operands
- ALUControlE  out  3
- WriteDataE, PCPlus4E, PCTargetE  out  XLEN
- RdE  out  RA_W; RegWriteE, MemWriteE  out  1; ResultSrcE  out  2
- PCSrcE  out  1  redirect Fetch to PCTargetE
- StallF, StallD, FlushD  out  1  hazard controls

Behaviour:
- E register loads on posedge clk. No enable: the E stage never stalls.
- Asynchronous reset (reset_n=0) clears every E register to 0. That is a bubble: RegWriteE=MemWriteE=BranchE=JumpE=0, RdE=0, ALUControlE=000, and all data outputs are 0.
- Combinational outputs reflect the cleared state while reset is held.
- FlushE = lwStall | PCSrcE. When set, the next edge loads a bubble (all zeros) instead of the D inputs.
- Priority: reset > flush > load.
- lwStall = ResultSrcE==01 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- StallF = StallD = lwStall. FlushD = PCSrcE.
- Combined stall/flush cost: load-use costs exactly one bubble; a taken branch or jump costs two squashed instructions (D and E).
- ForwardA (same rule for B using Rs2E):
  - 10 if RegWriteM & RdM!=0 & Rs1E==RdM;
  - else 01 if RegWriteW & RdW!=0 & Rs1E==RdW;
  - else 00.
  - Memory takes priority over Writeback when both match.
  - x0 is never forwarded.
- SrcAE = ForwardA mux of {RD1E, ResultW, ALUResultM}.
- WriteDataE = forwarded RD2E. SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- PCTargetE = PCE + ImmExtE, modulo 2^32.
- Branch taken, using ZeroE from the ALU in the same cycle (Decode sets SUB for beq/bne, SLT for blt/bge):
  - 000 beq: ZeroE
  - 001 bne: ~ZeroE
  - 100 blt: ~ZeroE
  - 101 bge: ZeroE
  - any other Funct3: not taken
- PCSrcE = (BranchE & taken) | JumpE.
- If lwStall and PCSrcE are both set in one cycle, the E flush occurs once, StallD and FlushD are both asserted, and FlushD governs.
- Path latency: one cycle from Decode inputs to E outputs. Forwarding and branch resolution are combinational within E.

Decomposition:
- `ALU_CTRL_ADD/SUB/AND/OR/SLT`, ResultSrc encodings, Forward encodings (00/01/10) and branch Funct3 codes belong in the shared defines header.
- One sub-module, hazard_unit: purely combinational; computes ForwardA/B, lwStall, StallF/StallD/FlushD/FlushE.
- The ID/EX register and operand muxes stay in id_ex_stage.

Test Plan:
- Reset mid-run: reset_n=0 while RegWriteD=1 and RdD=5 are presented -> RegWriteE=0, RdE=0, PCSrcE=0 immediately and held until the first edge after release.
- Forwarding priority: add x3 in E, RdM=3 with ALUResultM=0x10, RdW=3 with ResultW=0x20, RegWriteM=RegWriteW=1 -> SrcAE=0x10. Drop RegWriteM -> SrcAE=0x20. Use RdM=RdW=0 -> SrcAE=RD1E.
- Load-use: lw x4 in E (ResultSrcE=01, RdE=4), Rs2D=4 -> StallF=StallD=1 for exactly one cycle, and the next E contents are a bubble. With RdE=0 instead -> no stall.
- beq taken: BranchE=1, Funct3=000, ZeroE=1, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8, FlushD=1, and the next E is a bubble.
- bne/blt/bge/unsupported: ZeroE=0 with Funct3 001 -> taken; 101 -> not taken; 010 -> not taken. JumpE=1 -> PCSrcE=1 regardless of ZeroE.
- Immediate select: ALUSrcD=1, ImmExtD=0x7FF, forwarded RD2=0x55 -> SrcBE=0x7FF and WriteDataE=0x55.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared encodings for the ID/EX stage of the RV32I pipeline:
//               ALU control codes, ResultSrc encodings, forwarding selects,
//               branch Funct3 codes and the branch-condition helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

   // ALU operation codes carried from Decode to the ALU
   localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
   localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
   localparam logic [2:0] ALU_CTRL_AND = 3'b010;
   localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
   localparam logic [2:0] ALU_CTRL_SLT = 3'b101;

   // Writeback result source
   localparam logic [1:0] RES_SRC_ALU  = 2'b00;
   localparam logic [1:0] RES_SRC_LOAD = 2'b01;
   localparam logic [1:0] RES_SRC_PC4  = 2'b10;

   // Operand forwarding selects
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   // Branch condition codes (Funct3)
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   // Decode programs SUB for beq/bne and SLT for blt/bge, so every supported
   // condition reduces to the ALU Zero flag: SLT result 1 (Zero=0) means less.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
      logic taken;
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = ~zero;
         F3_BGE:  taken = zero;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between Decode/Memory/Writeback/ALU and the ID/EX
//               stage. The master side drives decoded fields, forwarding
//               sources and the ALU Zero flag; the slave side (the stage)
//               returns ALU operands, E-stage controls and hazard controls.
// Ports       : master - drives *D, *M, *W, ZeroE; reads E and hazard outputs
//               slave  - reads *D, *M, *W, ZeroE; drives E and hazard outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   // Decode-stage fields
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [RA_W-1:0] Rs1D, Rs2D, RdD;
   logic [2:0]      ALUControlD;
   logic            ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
   logic [1:0]      ResultSrcD;
   logic [2:0]      Funct3D;
   // Forwarding sources and ALU feedback
   logic [XLEN-1:0] ALUResultM, ResultW;
   logic [RA_W-1:0] RdM, RdW;
   logic            RegWriteM, RegWriteW;
   logic            ZeroE;
   // Execute-stage outputs
   logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE;
   logic [2:0]      ALUControlE;
   logic [RA_W-1:0] RdE;
   logic            RegWriteE, MemWriteE;
   logic [1:0]      ResultSrcE;
   logic            PCSrcE;
   // Hazard controls
   logic            StallF, StallD, FlushD;

   modport master (
      output RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ALUControlD,
             ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD, Funct3D,
             ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, ZeroE,
      input  SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE, ALUControlE, RdE,
             RegWriteE, MemWriteE, ResultSrcE, PCSrcE, StallF, StallD, FlushD
   );

   modport slave (
      input  RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ALUControlD,
             ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD, Funct3D,
             ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, ZeroE,
      output SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE, ALUControlE, RdE,
             RegWriteE, MemWriteE, ResultSrcE, PCSrcE, StallF, StallD, FlushD
   );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Purely combinational hazard logic for the E stage: operand
//               forwarding selects, load-use detection and the stall/flush
//               controls for Fetch, Decode and Execute.
// Ports       : rs1_d, rs2_d        - source registers of the Decode instr
//               rs1_e, rs2_e, rd_e  - registers of the Execute instr
//               result_src_e        - identifies a load in Execute
//               rd_m/reg_write_m, rd_w/reg_write_w - forwarding producers
//               pc_src_e            - taken branch / jump in Execute
//               forward_a/b         - operand selects (00 RF, 01 WB, 10 MEM)
//               stall_f, stall_d, flush_d, flush_e - pipeline controls
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
   import id_ex_stage_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] rs1_d,
   input  logic [RA_W-1:0] rs2_d,
   input  logic [RA_W-1:0] rs1_e,
   input  logic [RA_W-1:0] rs2_e,
   input  logic [RA_W-1:0] rd_e,
   input  logic [1:0]      result_src_e,
   input  logic [RA_W-1:0] rd_m,
   input  logic            reg_write_m,
   input  logic [RA_W-1:0] rd_w,
   input  logic            reg_write_w,
   input  logic            pc_src_e,
   output logic [1:0]      forward_a,
   output logic [1:0]      forward_b,
   output logic            stall_f,
   output logic            stall_d,
   output logic            flush_d,
   output logic            flush_e
);

   logic w_lw_stall;

   // Memory is the younger producer, so it wins over Writeback; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                          input logic [RA_W-1:0] rdm, input logic wem,
                                          input logic [RA_W-1:0] rdw, input logic wew);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (wem && (rdm != '0) && (rs == rdm))
         sel = FWD_MEM;
      else if (wew && (rdw != '0) && (rs == rdw))
         sel = FWD_WB;
      return sel;
   endfunction

   assign forward_a = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
   assign forward_b = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

   assign w_lw_stall = (result_src_e == RES_SRC_LOAD) && (rd_e != '0) &&
                       ((rs1_d == rd_e) || (rs2_d == rd_e));

   assign stall_f = w_lw_stall;
   assign stall_d = w_lw_stall;
   assign flush_d = pc_src_e;
   // A single bubble covers both causes when they coincide.
   assign flush_e = w_lw_stall | pc_src_e;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with execute-stage operand
//               selection, forwarding, branch resolution and hazard control
//               for a 5-stage RV32I pipeline. The E register never stalls;
//               a flush loads an all-zero bubble.
// Ports       : clk     - rising-edge clock
//               reset_n - asynchronous active-low reset (clears E to bubble)
//               bus     - id_ex_stage_if slave: Decode fields, M/W forwarding
//                         sources and ZeroE in; ALU operands, E controls,
//                         PCSrcE/PCTargetE and StallF/StallD/FlushD out
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   id_ex_stage_if.slave bus
);

   // E-stage register contents
   logic [XLEN-1:0] r_rd1_e, r_rd2_e, r_imm_e, r_pc_e, r_pc4_e;
   logic [RA_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;
   logic [2:0]      r_alu_ctrl_e, r_funct3_e;
   logic            r_alu_src_e, r_reg_write_e, r_mem_write_e, r_branch_e, r_jump_e;
   logic [1:0]      r_result_src_e;

   logic [1:0]      w_forward_a, w_forward_b;
   logic [XLEN-1:0] w_src_a, w_write_data;
   logic            w_pc_src_e, w_flush_e, w_stall_f, w_stall_d, w_flush_d;

   hazard_unit #(.RA_W(RA_W)) u_hazard (
      .rs1_d        (bus.Rs1D),
      .rs2_d        (bus.Rs2D),
      .rs1_e        (r_rs1_e),
      .rs2_e        (r_rs2_e),
      .rd_e         (r_rd_e),
      .result_src_e (r_result_src_e),
      .rd_m         (bus.RdM),
      .reg_write_m  (bus.RegWriteM),
      .rd_w         (bus.RdW),
      .reg_write_w  (bus.RegWriteW),
      .pc_src_e     (w_pc_src_e),
      .forward_a    (w_forward_a),
      .forward_b    (w_forward_b),
      .stall_f      (w_stall_f),
      .stall_d      (w_stall_d),
      .flush_d      (w_flush_d),
      .flush_e      (w_flush_e)
   );

   always_comb begin
      case (w_forward_a)
         FWD_MEM: w_src_a = bus.ALUResultM;
         FWD_WB:  w_src_a = bus.ResultW;
         default: w_src_a = r_rd1_e;
      endcase
      case (w_forward_b)
         FWD_MEM: w_write_data = bus.ALUResultM;
         FWD_WB:  w_write_data = bus.ResultW;
         default: w_write_data = r_rd2_e;
      endcase
   end

   // ZeroE comes back from the ALU within the same cycle.
   assign w_pc_src_e = (r_branch_e & branch_taken(r_funct3_e, bus.ZeroE)) | r_jump_e;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd1_e        <= '0;
         r_rd2_e        <= '0;
         r_imm_e        <= '0;
         r_pc_e         <= '0;
         r_pc4_e        <= '0;
         r_rs1_e        <= '0;
         r_rs2_e        <= '0;
         r_rd_e         <= '0;
         r_alu_ctrl_e   <= '0;
         r_funct3_e     <= '0;
         r_alu_src_e    <= 1'b0;
         r_reg_write_e  <= 1'b0;
         r_mem_write_e  <= 1'b0;
         r_branch_e     <= 1'b0;
         r_jump_e       <= 1'b0;
         r_result_src_e <= '0;
      end else begin
         // Flush loads the same all-zero bubble that reset produces.
         r_rd1_e        <= w_flush_e ? '0   : bus.RD1D;
         r_rd2_e        <= w_flush_e ? '0   : bus.RD2D;
         r_imm_e        <= w_flush_e ? '0   : bus.ImmExtD;
         r_pc_e         <= w_flush_e ? '0   : bus.PCD;
         r_pc4_e        <= w_flush_e ? '0   : bus.PCPlus4D;
         r_rs1_e        <= w_flush_e ? '0   : bus.Rs1D;
         r_rs2_e        <= w_flush_e ? '0   : bus.Rs2D;
         r_rd_e         <= w_flush_e ? '0   : bus.RdD;
         r_alu_ctrl_e   <= w_flush_e ? '0   : bus.ALUControlD;
         r_funct3_e     <= w_flush_e ? '0   : bus.Funct3D;
         r_alu_src_e    <= w_flush_e ? 1'b0 : bus.ALUSrcD;
         r_reg_write_e  <= w_flush_e ? 1'b0 : bus.RegWriteD;
         r_mem_write_e  <= w_flush_e ? 1'b0 : bus.MemWriteD;
         r_branch_e     <= w_flush_e ? 1'b0 : bus.BranchD;
         r_jump_e       <= w_flush_e ? 1'b0 : bus.JumpD;
         r_result_src_e <= w_flush_e ? '0   : bus.ResultSrcD;
      end
   end

   assign bus.SrcAE       = w_src_a;
   assign bus.WriteDataE  = w_write_data;
   assign bus.SrcBE       = r_alu_src_e ? r_imm_e : w_write_data;
   assign bus.ALUControlE = r_alu_ctrl_e;
   assign bus.PCPlus4E    = r_pc4_e;
   assign bus.PCTargetE   = r_pc_e + r_imm_e;
   assign bus.RdE         = r_rd_e;
   assign bus.RegWriteE   = r_reg_write_e;
   assign bus.MemWriteE   = r_mem_write_e;
   assign bus.ResultSrcE  = r_result_src_e;
   assign bus.PCSrcE      = w_pc_src_e;
   assign bus.StallF      = w_stall_f;
   assign bus.StallD      = w_stall_d;
   assign bus.FlushD      = w_flush_d;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. A behavioural model of
//               the E-stage contents is compared against every output on
//               each falling edge; directed vectors add literal expectations.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   running = 1'b1;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Model of the instruction currently held in Execute
   typedef struct packed {
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  alu, f3;
      logic        alusrc, rw, mw, br, j;
      logic [1:0]  rs;
   } e_t;
   e_t m;

   function automatic logic m_redirect(input e_t e, input logic zero);
      logic taken;
      taken = 1'b0;
      if (e.f3 == 3'd0 || e.f3 == 3'd5) taken = zero;        // beq, bge
      else if (e.f3 == 3'd1 || e.f3 == 3'd4) taken = !zero;  // bne, blt
      return (e.br && taken) || e.j;
   endfunction

   function automatic logic m_lw(input e_t e, input logic [4:0] a, input logic [4:0] b);
      return (e.rs == 2'b01) && (e.rd != 5'd0) && (a == e.rd || b == e.rd);
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
      if (bus.RegWriteM && bus.RdM != 5'd0 && rs == bus.RdM) return bus.ALUResultM;
      if (bus.RegWriteW && bus.RdW != 5'd0 && rs == bus.RdW) return bus.ResultW;
      return rf;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         m <= '0;
      else if (m_lw(m, bus.Rs1D, bus.Rs2D) || m_redirect(m, bus.ZeroE))
         m <= '0;
      else
         m <= '{rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.ImmExtD, pc: bus.PCD,
                pc4: bus.PCPlus4D, rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD,
                alu: bus.ALUControlD, f3: bus.Funct3D, alusrc: bus.ALUSrcD,
                rw: bus.RegWriteD, mw: bus.MemWriteD, br: bus.BranchD,
                j: bus.JumpD, rs: bus.ResultSrcD};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model
   always @(negedge clk) begin
      if (running) begin
         chk("SrcAE", bus.SrcAE, m_fwd(m.rs1, m.rd1));
         chk("WriteDataE", bus.WriteDataE, m_fwd(m.rs2, m.rd2));
         chk("SrcBE", bus.SrcBE, m.alusrc ? m.imm : m_fwd(m.rs2, m.rd2));
         chk("ALUControlE", 32'(bus.ALUControlE), 32'(m.alu));
         chk("PCPlus4E", bus.PCPlus4E, m.pc4);
         chk("PCTargetE", bus.PCTargetE, m.pc + m.imm);
         chk("RdE", 32'(bus.RdE), 32'(m.rd));
         chk("RegWriteE", 32'(bus.RegWriteE), 32'(m.rw));
         chk("MemWriteE", 32'(bus.MemWriteE), 32'(m.mw));
         chk("ResultSrcE", 32'(bus.ResultSrcE), 32'(m.rs));
         chk("PCSrcE", 32'(bus.PCSrcE), 32'(m_redirect(m, bus.ZeroE)));
         chk("StallF", 32'(bus.StallF), 32'(m_lw(m, bus.Rs1D, bus.Rs2D)));
         chk("StallD", 32'(bus.StallD), 32'(m_lw(m, bus.Rs1D, bus.Rs2D)));
         chk("FlushD", 32'(bus.FlushD), 32'(m_redirect(m, bus.ZeroE)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.RD1D = '0; bus.RD2D = '0; bus.ImmExtD = '0; bus.PCD = '0; bus.PCPlus4D = '0;
      bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0; bus.ALUControlD = '0;
      bus.ALUSrcD = 0; bus.RegWriteD = 0; bus.MemWriteD = 0; bus.BranchD = 0; bus.JumpD = 0;
      bus.ResultSrcD = '0; bus.Funct3D = '0;
      bus.ALUResultM = '0; bus.ResultW = '0; bus.RdM = '0; bus.RdW = '0;
      bus.RegWriteM = 0; bus.RegWriteW = 0; bus.ZeroE = 0;
   endtask

   // Load a branch with the given Funct3, then check PCSrcE under zero
   task automatic branch_case(input logic [2:0] f3, input logic zero, input logic exp);
      idle();
      tick();
      bus.BranchD = 1; bus.Funct3D = f3; bus.ALUControlD = ALU_CTRL_SUB;
      tick();
      idle();
      bus.ZeroE = zero;
      #1 chk("branch_pcsrc", 32'(bus.PCSrcE), 32'(exp));
   endtask

   initial begin
      idle();
      // Reset held while a write to x5 is presented
      reset_n = 0;
      bus.RegWriteD = 1; bus.RdD = 5;
      tick(); tick();
      #1 chk("rst_regwrite", 32'(bus.RegWriteE), 32'd0);
      chk("rst_rd", 32'(bus.RdE), 32'd0);
      chk("rst_pcsrc", 32'(bus.PCSrcE), 32'd0);
      reset_n = 1;
      tick();
      #1 chk("load_rd", 32'(bus.RdE), 32'd5);
      // Mid-run reset clears immediately and holds across an edge
      reset_n = 0;
      #1 chk("midrst_regwrite", 32'(bus.RegWriteE), 32'd0);
      chk("midrst_rd", 32'(bus.RdE), 32'd0);
      tick();
      #1 chk("midrst_hold", 32'(bus.RdE), 32'd0);
      reset_n = 1;
      tick();
      #1 chk("postrst_rd", 32'(bus.RdE), 32'd5);

      // Forwarding priority on operand A, writeback forwarding on B
      idle();
      bus.Rs1D = 3; bus.Rs2D = 6; bus.RdD = 3; bus.RD1D = 32'h111; bus.RD2D = 32'h66;
      bus.RegWriteD = 1; bus.ALUControlD = ALU_CTRL_ADD;
      tick();
      bus.RdM = 3; bus.ALUResultM = 32'h10; bus.RegWriteM = 1;
      bus.RdW = 3; bus.ResultW = 32'h20; bus.RegWriteW = 1;
      #1 chk("fwd_mem", bus.SrcAE, 32'h10);
      bus.RegWriteM = 0;
      #1 chk("fwd_wb", bus.SrcAE, 32'h20);
      bus.RegWriteM = 1; bus.RdM = 0; bus.RdW = 0;
      #1 chk("fwd_x0", bus.SrcAE, 32'h111);
      bus.RdW = 6;
      #1 chk("fwd_b_wb", bus.WriteDataE, 32'h20);
      tick();

      // Load-use: lw x4 followed by a reader of x4
      idle();
      bus.ResultSrcD = RES_SRC_LOAD; bus.RdD = 4; bus.RegWriteD = 1;
      tick();
      idle();
      bus.Rs2D = 4; bus.RdD = 7; bus.RegWriteD = 1;
      #1 chk("lu_stallf", 32'(bus.StallF), 32'd1);
      chk("lu_stalld", 32'(bus.StallD), 32'd1);
      chk("lu_flushd", 32'(bus.FlushD), 32'd0);
      tick();
      #1 chk("lu_bubble_rd", 32'(bus.RdE), 32'd0);
      chk("lu_bubble_rw", 32'(bus.RegWriteE), 32'd0);
      chk("lu_one_cycle", 32'(bus.StallF), 32'd0);
      tick();
      #1 chk("lu_reissue", 32'(bus.RdE), 32'd7);
      // Load to x0 never stalls
      idle();
      bus.ResultSrcD = RES_SRC_LOAD; bus.RdD = 0;
      tick();
      idle();
      #1 chk("lu_x0", 32'(bus.StallF), 32'd0);

      // beq taken with backward offset
      idle();
      tick();
      bus.BranchD = 1; bus.Funct3D = F3_BEQ; bus.PCD = 32'h100; bus.ImmExtD = 32'hFFFF_FFF8;
      bus.ALUControlD = ALU_CTRL_SUB;
      tick();
      idle();
      bus.ZeroE = 1; bus.RegWriteD = 1; bus.RdD = 9;
      #1 chk("beq_pcsrc", 32'(bus.PCSrcE), 32'd1);
      chk("beq_target", bus.PCTargetE, 32'h0000_00F8);
      chk("beq_flushd", 32'(bus.FlushD), 32'd1);
      tick();
      #1 chk("beq_bubble", 32'(bus.RdE), 32'd0);
      chk("beq_bubble_pcsrc", 32'(bus.PCSrcE), 32'd0);

      branch_case(F3_BNE, 1'b0, 1'b1);
      branch_case(F3_BGE, 1'b0, 1'b0);
      branch_case(3'b010, 1'b0, 1'b0);
      branch_case(F3_BLT, 1'b0, 1'b1);
      branch_case(F3_BEQ, 1'b0, 1'b0);

      // Jump redirects regardless of ZeroE
      idle();
      tick();
      bus.JumpD = 1;
      tick();
      idle();
      #1 chk("jal_z0", 32'(bus.PCSrcE), 32'd1);
      bus.ZeroE = 1;
      #1 chk("jal_z1", 32'(bus.PCSrcE), 32'd1);

      // Load-use and redirect in the same cycle: one bubble, both controls
      idle();
      tick();
      bus.JumpD = 1; bus.ResultSrcD = RES_SRC_LOAD; bus.RdD = 4; bus.RegWriteD = 1;
      tick();
      idle();
      bus.Rs1D = 4; bus.RdD = 8; bus.RegWriteD = 1;
      #1 chk("both_stalld", 32'(bus.StallD), 32'd1);
      chk("both_flushd", 32'(bus.FlushD), 32'd1);
      tick();
      #1 chk("both_bubble", 32'(bus.RdE), 32'd0);
      tick();
      #1 chk("both_next", 32'(bus.RdE), 32'd8);

      // Immediate select with forwarded store data
      idle();
      bus.ALUSrcD = 1; bus.ImmExtD = 32'h7FF; bus.Rs2D = 2; bus.RD2D = 32'h12;
      bus.MemWriteD = 1; bus.PCPlus4D = 32'h204; bus.ALUControlD = ALU_CTRL_OR;
      tick();
      bus.RdM = 2; bus.ALUResultM = 32'h55; bus.RegWriteM = 1;
      #1 chk("imm_srcb", bus.SrcBE, 32'h7FF);
      chk("imm_wdata", bus.WriteDataE, 32'h55);
      chk("imm_pc4", bus.PCPlus4E, 32'h204);
      chk("imm_aluctl", 32'(bus.ALUControlE), 32'(ALU_CTRL_OR));
      tick();
      tick();

      running = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
